// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier for MUL, MULHU and approximate MUL_APX.
// Latency is data-independent: XLEN iterations, or XLEN-APX_SKIP for MUL_APX.
module alu_mul_sequencer #(
    parameter int XLEN     = 32,
    parameter int APX_SKIP = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] OP_MULHU = 2'd1;
    localparam logic [1:0] OP_APX   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    state_e              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]       count_q, count_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2*XLEN-1:0]   acc_sum;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    acc_d   = '0;
                    if (op == OP_APX) begin
                        // Low multiplier bits are dropped; the multiplicand is
                        // pre-shifted so the remaining bits keep their weight.
                        mcand_d  = {{XLEN{1'b0}}, operand_a} << APX_SKIP;
                        mplier_d = operand_b >> APX_SKIP;
                        count_d  = CW'(XLEN - APX_SKIP);
                    end else begin
                        mcand_d  = {{XLEN{1'b0}}, operand_a};
                        mplier_d = operand_b;
                        count_d  = CW'(XLEN);
                    end
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = FIN;
                    if (op_q == OP_MULHU) result_d = acc_sum[2*XLEN-1:XLEN];
                    else                  result_d = acc_sum[XLEN-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == FIN);
    assign result = result_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: latency, results, start/reset corner cases.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_alu_mul_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int pass_cnt = 0;
    int total = 0;

    alu_mul_sequencer #(.XLEN(32), .APX_SKIP(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request in the current cycle t; returns in cycle t+1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        op = o;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        reset = 1'b0;
        total++;
        if ({busy, done, result} !== 34'd0)
            $display("FAIL reset_state busy=%b done=%b result=%h want 0/0/0",
                     busy, done, result);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) bad++;
            tick();
        end
        total++;
        if (bad !== 0)
            $display("FAIL reset_idle bad_cycles=%0d want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        int bad;
        launch(2'd0, 32'd7, 32'd6);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        total++;
        if (bad !== 0) $display("FAIL mul_busy bad_cycles=%0d want 0", bad);
        else pass_cnt++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd42)
            $display("FAIL mul_done done=%b busy=%b result=%0d want 1/0/42",
                     done, busy, result);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd42) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL mul_hold bad_cycles=%0d want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_mulhu();
        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) tick();
        total++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFFE)
            $display("FAIL mulhu done=%b result=%h want 1/fffffffe", done, result);
        else pass_cnt++;
        tick();
        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) tick();
        total++;
        if (done !== 1'b1 || result !== 32'h0000_0001)
            $display("FAIL mul_ones done=%b result=%h want 1/00000001", done, result);
        else pass_cnt++;
        tick();
        launch(2'd3, 32'd1000, 32'd77);
        repeat (32) tick();
        total++;
        if (done !== 1'b1 || result !== 32'd77000)
            $display("FAIL op3 done=%b result=%0d want 1/77000", done, result);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_apx();
        int bad;
        launch(2'd2, 32'd3, 32'h0000_01FF);
        bad = 0;
        for (int k = 1; k <= 24; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        total++;
        if (bad !== 0) $display("FAIL apx_busy bad_cycles=%0d want 0", bad);
        else pass_cnt++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'h0000_0300)
            $display("FAIL apx_done done=%b busy=%b result=%h want 1/0/00000300",
                     done, busy, result);
        else pass_cnt++;
        tick();
        launch(2'd0, 32'd3, 32'h0000_01FF);
        repeat (32) tick();
        total++;
        if (done !== 1'b1 || result !== 32'h0000_05FD)
            $display("FAIL apx_exact done=%b result=%h want 1/000005fd", done, result);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int bad;
        launch(2'd0, 32'd9, 32'd11);
        op = 2'd0;
        operand_a = 32'd5;
        operand_b = 32'd5;
        start = 1'b1;
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        total++;
        if (bad !== 0) $display("FAIL ignore_busy bad_cycles=%0d want 0", bad);
        else pass_cnt++;
        total++;
        if (done !== 1'b1 || result !== 32'd99)
            $display("FAIL ignore_first done=%b result=%0d want 1/99", done, result);
        else pass_cnt++;
        tick();
        start = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1234_5678;
        total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy, done);
        else pass_cnt++;
        repeat (32) tick();
        total++;
        if (done !== 1'b1 || result !== 32'd25)
            $display("FAIL b2b_second done=%b result=%0d want 1/25", done, result);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int dones;
        launch(2'd0, 32'd100, 32'd100);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0)
            $display("FAIL abort_state busy=%b done=%b result=%0d want 0/0/0",
                     busy, done, result);
        else pass_cnt++;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) dones++;
            tick();
        end
        total++;
        if (dones !== 0 || result !== 32'd0)
            $display("FAIL abort_quiet bad_cycles=%0d result=%0d want 0/0",
                     dones, result);
        else pass_cnt++;
        launch(2'd0, 32'd2, 32'd3);
        repeat (32) tick();
        total++;
        if (done !== 1'b1 || result !== 32'd6)
            $display("FAIL after_abort done=%b result=%0d want 1/6", done, result);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_mul();
        test_mulhu();
        test_apx();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
